iq_dequant: RTL and testbench
=============================

Name: iq_dequant

Overview:
Inverse-quantization stage of the JPEG decoder datapath. It accepts a stream of 64 quantized coefficients per 8x8 block and addresses the 64x8 inverse-quantization ROM (romq) with each coefficient's index. It multiplies each coefficient by the returned quantization value, saturates the product and passes it downstream to the IDCT input buffer. The block sits directly between the entropy decoder and the IDCT and owns the romq address bus.

Parameters:
COEF_W, 12, signed input coefficient width
Q_W, 8, unsigned quantization value width (matches romq d)
OUT_W, 16, signed output width; products saturate to this range

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  coefficient present on in_coef
in_ready  out  1  stage can accept a coefficient this cycle
in_coef  in  COEF_W  signed quantized coefficient
in_sob  in  1  qualifies the first coefficient of a block (index 0)
rom_a  out  6  address to romq
rom_d  in  Q_W  romq data, valid one clk after rom_a is sampled
out_valid  out  1  dequantized coefficient present
out_ready  in  1  downstream accepts
out_coef  out  OUT_W  signed saturated product
out_eob  out  1  qualifies the 64th coefficient of a block
sync_err  out  1  one-cycle pulse on block resynchronisation

Behaviour:
- Reset (async, rst_n=0): idx=0, all stage valids=0, out_valid=0, out_coef=0, out_eob=0, sync_err=0, rom_a=0. State returns to IDLE immediately, mid-block or not; partial block discarded.
- Accept: transfer when in_valid && in_ready. stall = out_valid && !out_ready; in_ready = !stall.
- Pipeline: S1 registers coef, idx, eob-flag and issues rom_a; S2 (output register) captures sat(coef*rom_d). Latency is 2 clk from accept to out_valid with no stall.
- rom_a = stall ? S1.idx : idx_next_accept. While stalled, rom_a holds S1's index so rom_d stays valid for S1.
- Index counter idx (6 bit): advances on every accept and wraps 63->0. Index 63 sets the eob flag carried with that coefficient.
- FSM: IDLE (idx=0, awaiting in_sob) -> RUN on accepted in_sob. RUN -> IDLE after accepting index 63. In IDLE, accepted coefficients without in_sob are dropped (accepted, not forwarded, idx unchanged).
- In RUN, an accepted in_sob with idx!=0 restarts the block at index 0, pulses sync_err for 1 clk and forwards that coefficient as index 0. Coefficients already in the pipeline still drain.
- in_sob at idx=0 in RUN is legal; sync_err is not raised.
- Arithmetic: signed(COEF_W) x unsigned(Q_W) -> COEF_W+Q_W+1 bit signed. Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Outputs hold value while out_valid && !out_ready. out_coef is undefined-free: it keeps its last value when out_valid=0.
- Simultaneous downstream consume and upstream accept in one cycle: full throughput of 1 coef/clk.

Decomposition:
- Shared package/header: COEF_W, Q_W, OUT_W defaults, BLOCK_LEN=64, and the FSM state encodings IDLE/RUN.
- One sub-module: iq_sat_mul (signed x unsigned multiply plus saturation, combinational, parameterised). It is reused by a later chroma path.
- romq stays external; the bench instantiates a behavioural romq stub.

Test Plan:
- Stub ROM rom_d=a+1 (registered). Stream sob + coefs 1..64, out_ready=1 -> out_coef[k]=(k+1)*(k+1); out_eob only on the 64th; first output 2 clk after first accept.
- in_coef=2047 with rom_d=255 -> out_coef=32767 (clamped from 521985). in_coef=-2048 with rom_d=255 -> -32768.
- out_ready low for 5 clk mid-block at idx 10 -> in_ready=0 during stall, rom_a held at 10, no loss or duplication, sequence resumes correctly.
- New sob at idx 20 -> sync_err pulses once, next outputs use rom_a 0,1,2...; the earlier 20 outputs all emerge.
- Coefficients without sob after reset -> no out_valid; idx stays 0.
- rst_n low at idx 37 with pipeline full -> out_valid=0 asynchronously; the next sob block runs cleanly from index 0.

Source files
------------

// File: rtl/iq_dequant_pkg.sv
// Shared widths, block length and FSM encodings for the dequant stage.
package iq_dequant_pkg;
  localparam int COEF_W_D  = 12;
  localparam int Q_W_D     = 8;
  localparam int OUT_W_D   = 16;
  localparam int BLOCK_LEN = 64;
  localparam int IDX_W     = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/iq_sat_mul.sv
// Signed coefficient times unsigned quant value, clamped to OUT_W signed.
module iq_sat_mul #(
  parameter int COEF_W = 12,
  parameter int Q_W    = 8,
  parameter int OUT_W  = 16
) (
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic        [Q_W-1:0]    i_q,
  output logic signed [OUT_W-1:0]  o_res
);
  // One extra bit lets the unsigned operand ride as a positive signed value.
  localparam int PW = COEF_W + Q_W + 1;
  localparam logic signed [PW-1:0] MAXV = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [PW-1:0] w_a, w_b, w_prod;

  assign w_a    = PW'(i_coef);
  assign w_b    = {{(PW-Q_W){1'b0}}, i_q};
  assign w_prod = w_a * w_b;

  // Clamp anything outside the output range to the nearest rail.
  always_comb begin
    o_res = w_prod[OUT_W-1:0];
    if (w_prod > MAXV)      o_res = MAXV[OUT_W-1:0];
    else if (w_prod < MINV) o_res = MINV[OUT_W-1:0];
  end
endmodule

// File: rtl/iq_dequant.sv
// JPEG inverse quantization: index coefficients, fetch romq, multiply, saturate.
module iq_dequant
  import iq_dequant_pkg::*;
#(
  parameter int COEF_W = COEF_W_D,
  parameter int Q_W    = Q_W_D,
  parameter int OUT_W  = OUT_W_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     in_sob,
  output logic [IDX_W-1:0]         rom_a,
  input  logic [Q_W-1:0]           rom_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_coef,
  output logic                     out_eob,
  output logic                     sync_err
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCK_LEN - 1);

  state_e                   r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_idx, w_idx_nxt, w_fwd_idx;
  logic                     w_stall, w_acc, w_fwd, w_sync;
  logic                     r_s1_vld, r_s1_eob;
  logic signed [COEF_W-1:0] r_s1_coef;
  logic [IDX_W-1:0]         r_s1_idx;
  logic                     r_out_valid, r_out_eob, r_sync_err;
  logic signed [OUT_W-1:0]  r_out_coef, w_prod_sat;

  // Whole pipe advances together; only the output register can stall it.
  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_acc    = in_valid && in_ready;

  // While stalled keep S1's address so rom_d stays aligned with S1.
  assign rom_a = w_stall ? r_s1_idx : w_fwd_idx;

  // Block tracking: decide forward/drop, next index and resync.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_fwd       = 1'b0;
    w_sync      = 1'b0;
    w_fwd_idx   = in_sob ? '0 : r_idx;
    if (r_state == IDLE) begin
      if (w_acc && in_sob) begin
        w_fwd       = 1'b1;
        w_idx_nxt   = IDX_W'(1);
        w_state_nxt = RUN;
      end
    end else if (w_acc) begin
      w_fwd = 1'b1;
      if (in_sob) begin
        w_sync    = (r_idx != '0);
        w_idx_nxt = IDX_W'(1);
      end else if (r_idx == LAST) begin
        w_idx_nxt   = '0;
        w_state_nxt = IDLE;
      end else begin
        w_idx_nxt = r_idx + IDX_W'(1);
      end
    end
  end

  // FSM state and index counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // S1: hold coefficient and index while romq looks up the quant value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_coef <= '0;
      r_s1_idx  <= '0;
      r_s1_eob  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_vld <= w_fwd;
      if (w_fwd) begin
        r_s1_coef <= in_coef;
        r_s1_idx  <= w_fwd_idx;
        r_s1_eob  <= (w_fwd_idx == LAST);
      end
    end
  end

  iq_sat_mul #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) u_mul (
    .i_coef (r_s1_coef),
    .i_q    (rom_d),
    .o_res  (w_prod_sat)
  );

  // S2: output register; payload only changes when a new coefficient lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_coef  <= '0;
      r_out_eob   <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_coef <= w_prod_sat;
        r_out_eob  <= r_s1_eob;
      end
    end
  end

  // One-cycle resync pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync_err <= 1'b0;
    else        r_sync_err <= w_sync;
  end

  assign out_valid = r_out_valid;
  assign out_coef  = r_out_coef;
  assign out_eob   = r_out_eob;
  assign sync_err  = r_sync_err;
endmodule

// File: tb/tb_iq_dequant.sv
// Directed bench for iq_dequant with a registered romq stub.
module tb_iq_dequant;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0, in_ready, in_sob = 1'b0;
  logic signed [11:0] in_coef = '0;
  logic [5:0]         rom_a;
  logic [7:0]         rom_d = '0;
  logic               out_valid, out_ready = 1'b1, out_eob, sync_err;
  logic signed [15:0] out_coef;
  logic               rom_const = 1'b0;

  int n_chk = 0, n_fail = 0, sync_cnt = 0;
  int q_c[$];
  bit q_e[$];

  iq_dequant dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_coef(in_coef), .in_sob(in_sob), .rom_a(rom_a), .rom_d(rom_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_eob(out_eob), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // romq stub: data is address+1, or a constant 255 for saturation tests
  always_ff @(posedge clk) rom_d <= rom_const ? 8'd255 : {2'b0, rom_a} + 8'd1;

  // capture every downstream transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_c.push_back(int'(32'($signed(out_coef))));
      q_e.push_back(out_eob);
    end
    if (rst_n && sync_err) sync_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sob = 1'b0; in_coef = '0;
    out_ready = 1'b1; rom_const = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    q_c.delete(); q_e.delete(); sync_cnt = 0;
  endtask

  // call between posedge+1 and the following negedge; returns at posedge+1 after accept
  task automatic send(input int c, input bit s);
    int n;
    in_valid = 1'b1; in_coef = 12'(c); in_sob = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sob = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  // block of coef k+1 at index k gives (k+1)^2 with rom_d = k+1
  task automatic chk_blk(input int n_size, input int n_pref);
    chk("q_size", q_c.size(), n_size);
    for (int k = 0; k < n_pref && k < q_c.size(); k++) begin
      chk($sformatf("coef[%0d]", k), q_c[k], (k + 1) * (k + 1));
      chk($sformatf("eob[%0d]", k), 32'(q_e[k]), (k == 63) ? 1 : 0);
    end
  endtask

  initial begin
    // reset state and full block, latency
    do_reset();
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_oc", 32'($signed(out_coef)), 0);
    chk("rst_eob", 32'(out_eob), 0);
    chk("rst_sync", 32'(sync_err), 0);
    chk("rst_rom_a", 32'(rom_a), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    send(1, 1'b1);
    @(negedge clk); chk("lat1_ov", 32'(out_valid), 0);
    @(negedge clk); chk("lat2_ov", 32'(out_valid), 1);
    chk("lat2_oc", 32'($signed(out_coef)), 1);
    @(posedge clk); #1;
    for (int k = 1; k < 64; k++) send(k + 1, 1'b0);
    drain();
    chk_blk(64, 64);
    chk("blk_sync", sync_cnt, 0);

    // saturation
    do_reset();
    rom_const = 1'b1;
    @(posedge clk); #1;
    send(2047, 1'b1);
    send(-2048, 1'b0);
    send(-100, 1'b0);
    drain();
    chk("sat_size", q_c.size(), 3);
    if (q_c.size() == 3) begin
      chk("sat_pos", q_c[0], 32767);
      chk("sat_neg", q_c[1], -32768);
      chk("sat_mid", q_c[2], -25500);
    end

    // downstream stall mid-block
    do_reset();
    for (int k = 0; k <= 10; k++) send(k + 1, k == 0);
    out_ready = 1'b0; in_valid = 1'b1; in_coef = 12'sd12; in_sob = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_rom_a", 32'(rom_a), 10);
      chk("stall_ov", 32'(out_valid), 1);
      chk("stall_oc", 32'($signed(out_coef)), 100);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 11; k < 64; k++) send(k + 1, 1'b0);
    drain();
    chk_blk(64, 64);

    // resync by sob at index 20
    do_reset();
    for (int k = 0; k < 20; k++) send(k + 1, k == 0);
    in_valid = 1'b1; in_sob = 1'b1; in_coef = 12'sd100;
    #1 chk("resync_rom_a", 32'(rom_a), 0);
    send(100, 1'b1);
    send(101, 1'b0);
    send(102, 1'b0);
    drain();
    chk_blk(23, 20);
    if (q_c.size() == 23) begin
      chk("resync0", q_c[20], 100);
      chk("resync1", q_c[21], 202);
      chk("resync2", q_c[22], 306);
    end
    chk("resync_pulses", sync_cnt, 1);

    // coefficients without sob are dropped, idx stays 0
    do_reset();
    for (int k = 0; k < 5; k++) send(50 + k, 1'b0);
    drain();
    chk("nosob_size", q_c.size(), 0);
    chk("nosob_rom_a", 32'(rom_a), 0);
    send(3, 1'b1);
    send(4, 1'b0);
    drain();
    chk("nosob_after_size", q_c.size(), 2);
    if (q_c.size() == 2) begin
      chk("nosob_idx0", q_c[0], 3);
      chk("nosob_idx1", q_c[1], 8);
    end

    // async reset with pipe full at index 37
    do_reset();
    for (int k = 0; k <= 37; k++) send(k + 1, k == 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 0);
    chk("arst_oc", 32'($signed(out_coef)), 0);
    chk("arst_rom_a", 32'(rom_a), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    q_c.delete(); q_e.delete(); sync_cnt = 0;
    for (int k = 0; k < 64; k++) send(k + 1, k == 0);
    drain();
    chk_blk(64, 64);
    chk("arst_sync", sync_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
